// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - time-multiplexed multi-digit 7-segment driver
// Snapshots the input once per frame and scans digits with a dark window per slot.
module seven_segment_scanner #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] number,
  input  logic [N_DIGITS-1:0]   dots,
  input  logic                  blank_zeros,
  output logic [6:0]            abcdefg,
  output logic                  dot,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic                  frame_start
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRE_LIT  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] num_q, num_d;
  logic [N_DIGITS-1:0]   dots_q, dots_d;
  logic                  bz_q, bz_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dot_q, dot_d;
  logic [N_DIGITS-1:0]   en_q, en_d;
  logic                  fs_q, fs_d;

  logic [3:0]            nib [N_DIGITS];
  logic [N_DIGITS-1:0]   blank_vec;
  logic                  snap;
  logic                  lit;
  logic                  upper_zero;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0:    glyph = 7'b1111110;
      4'h1:    glyph = 7'b0110000;
      4'h2:    glyph = 7'b1101101;
      4'h3:    glyph = 7'b1111001;
      4'h4:    glyph = 7'b0110011;
      4'h5:    glyph = 7'b1011011;
      4'h6:    glyph = 7'b1011111;
      4'h7:    glyph = 7'b1110000;
      4'h8:    glyph = 7'b1111111;
      4'h9:    glyph = 7'b1111011;
      4'hA:    glyph = 7'b1110111;
      4'hB:    glyph = 7'b0011111;
      4'hC:    glyph = 7'b1001110;
      4'hD:    glyph = 7'b0111101;
      4'hE:    glyph = 7'b1001111;
      default: glyph = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // The snapshot edge sits in slot 0's dark window, so no frame ever tears.
    snap   = (pre_q == '0) && (idx_q == '0);
    num_d  = snap ? number      : num_q;
    dots_d = snap ? dots        : dots_q;
    bz_d   = snap ? blank_zeros : bz_q;
  end

  // Walk from the most significant digit down; a digit blanks while everything above it is zero.
  always_comb begin
    upper_zero = 1'b1;
    blank_vec  = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      nib[k]       = num_q[4*k +: 4];
      upper_zero   = upper_zero && (nib[k] == 4'h0);
      blank_vec[k] = bz_q && upper_zero && (k != 0);
    end
  end

  always_comb begin
    lit   = (pre_q >= PRE_LIT);
    fs_d  = snap;
    seg_d = '0;
    dot_d = 1'b0;
    en_d  = '0;
    if (lit) begin
      en_d[idx_q] = 1'b1;
      dot_d       = dots_q[idx_q];
      seg_d       = blank_vec[idx_q] ? 7'b0000000 : glyph(nib[idx_q]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q  <= '0;
      idx_q  <= '0;
      num_q  <= '0;
      dots_q <= '0;
      bz_q   <= 1'b0;
      seg_q  <= '0;
      dot_q  <= 1'b0;
      en_q   <= '0;
      fs_q   <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      num_q  <= num_d;
      dots_q <= dots_d;
      bz_q   <= bz_d;
      seg_q  <= seg_d;
      dot_q  <= dot_d;
      en_q   <= en_d;
      fs_q   <= fs_d;
    end
  end

  assign abcdefg     = seg_q;
  assign dot         = dot_q;
  assign digit_en    = en_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - self-checking bench for seven_segment_scanner
// Frame-arithmetic reference model with directed test-plan checks and random stimulus.
module tb_seven_segment_scanner;

  localparam int N  = 4;
  localparam int R  = 8;
  localparam int B  = 2;
  localparam int NR = N * R;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic        clk;
  logic        reset;
  logic [15:0] number;
  logic [3:0]  dots;
  logic        blank_zeros;
  logic [6:0]  abcdefg;
  logic        dot;
  logic [3:0]  digit_en;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  // cnt: label of the current cycle (cycles since release, -1 while held in reset)
  int          cnt = -1;
  logic [15:0] s_num  = '0;
  logic [3:0]  s_dots = '0;
  logic        s_bz   = 1'b0;

  logic [6:0] o_seg [80];
  logic [3:0] o_en  [80];
  logic       o_dot [80];
  logic       o_fs  [80];

  seven_segment_scanner #(
    .N_DIGITS    (N),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .number     (number),
    .dots       (dots),
    .blank_zeros(blank_zeros),
    .abcdefg    (abcdefg),
    .dot        (dot),
    .digit_en   (digit_en),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] num, input logic [3:0] dt, input logic bzv);
    logic [6:0]  e_seg;
    logic [3:0]  e_en;
    logic        e_dot;
    logic        e_fs;
    logic [15:0] upper;
    int          s, w, di, pr, e;
    @(negedge clk);
    e_seg = '0;
    e_en  = '0;
    e_dot = 1'b0;
    e_fs  = 1'b0;
    if (cnt >= 1) begin
      s    = cnt - 1;
      w    = s % NR;
      di   = w / R;
      pr   = w % R;
      e_fs = (w == 0);
      if (pr >= B) begin
        e_en  = 4'(1 << di);
        e_dot = s_dots[di];
        upper = s_num >> (4 * di);
        e_seg = (s_bz && di > 0 && upper == 16'h0) ? 7'b0 : GLYPH[int'(upper[3:0])];
      end
    end
    check_val($sformatf("seg@%0d", cnt), 32'(abcdefg), 32'(e_seg));
    check_val($sformatf("en@%0d", cnt), 32'(digit_en), 32'(e_en));
    check_val($sformatf("dot@%0d", cnt), 32'(dot), 32'(e_dot));
    check_val($sformatf("fs@%0d", cnt), 32'(frame_start), 32'(e_fs));
    if (cnt >= 0 && cnt < 80) begin
      o_seg[cnt] = abcdefg;
      o_en[cnt]  = digit_en;
      o_dot[cnt] = dot;
      o_fs[cnt]  = frame_start;
    end
    reset       = r;
    number      = num;
    dots        = dt;
    blank_zeros = bzv;
    if (!r) begin
      e = (cnt < 0) ? 0 : cnt;
      if (e % NR == 0) begin
        s_num  = num;
        s_dots = dt;
        s_bz   = bzv;
      end
    end
    cnt = r ? -1 : ((cnt < 0) ? 1 : cnt + 1);
  endtask

  initial begin
    logic [15:0] rnum;
    logic [3:0]  rdots;
    logic        rbz;
    logic        rr;
    reset       = 1'b1;
    number      = 16'h1234;
    dots        = '0;
    blank_zeros = 1'b0;

    // Reset, first frame, full scan, and no tearing on a mid-frame change
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1234, 4'b0, 1'b0);
    for (int c = 0; c < 70; c++) step(1'b0, (c >= 12) ? 16'hABCD : 16'h1234, 4'b0, 1'b0);
    check_val("s1_fs1", 32'(o_fs[1]), 32'd1);
    check_val("s1_fs2", 32'(o_fs[2]), 32'd0);
    check_val("s1_en3", 32'(o_en[3]), 32'b0001);
    check_val("s1_seg3", 32'(o_seg[3]), 32'b0110011);
    check_val("s1_seg8", 32'(o_seg[8]), 32'b0110011);
    check_val("s1_dark9", 32'(o_en[9]), 32'd0);
    check_val("s1_dark10", 32'(o_seg[10]), 32'd0);
    check_val("s2_en11", 32'(o_en[11]), 32'b0010);
    check_val("s2_seg16", 32'(o_seg[16]), 32'b1111001);
    check_val("s2_seg19", 32'(o_seg[19]), 32'b1101101);
    check_val("s3_seg24", 32'(o_seg[24]), 32'b1101101);
    check_val("s2_seg27", 32'(o_seg[27]), 32'b0110000);
    check_val("s3_seg32", 32'(o_seg[32]), 32'b0110000);
    check_val("s2_fs33", 32'(o_fs[33]), 32'd1);
    check_val("s3_seg35", 32'(o_seg[35]), 32'b0111101);
    check_val("s3_seg60", 32'(o_seg[60]), 32'b1110111);

    // Leading-zero blanking and decimal points
    step(1'b1, 16'h0070, 4'b0100, 1'b1);
    for (int c = 0; c < 40; c++) step(1'b0, 16'h0070, 4'b0100, 1'b1);
    check_val("s4_en6", 32'(o_en[6]), 32'b0001);
    check_val("s4_seg6", 32'(o_seg[6]), 32'b1111110);
    check_val("s4_seg14", 32'(o_seg[14]), 32'b1110000);
    check_val("s4_en22", 32'(o_en[22]), 32'b0100);
    check_val("s4_seg22", 32'(o_seg[22]), 32'd0);
    check_val("s4_en30", 32'(o_en[30]), 32'b1000);
    check_val("s4_seg30", 32'(o_seg[30]), 32'd0);
    check_val("s5_dot22", 32'(o_dot[22]), 32'd1);
    check_val("s5_dot14", 32'(o_dot[14]), 32'd0);
    check_val("s5_dot18", 32'(o_dot[18]), 32'd0);
    step(1'b1, 16'h0000, 4'b0, 1'b1);
    for (int c = 0; c < 40; c++) step(1'b0, 16'h0000, 4'b0, 1'b1);
    check_val("s4z_seg6", 32'(o_seg[6]), 32'b1111110);
    check_val("s4z_seg14", 32'(o_seg[14]), 32'd0);
    check_val("s4z_en14", 32'(o_en[14]), 32'b0010);

    // Reset mid-slot at idx=2, pre=5
    step(1'b1, 16'h1234, 4'b0, 1'b0);
    for (int c = 0; c < 21; c++) step(1'b0, 16'h1234, 4'b0, 1'b0);
    step(1'b1, 16'h5678, 4'b0, 1'b0);
    step(1'b0, 16'h5678, 4'b0, 1'b0);
    check_val("s6_zero_en", 32'(digit_en), 32'd0);
    check_val("s6_zero_seg", 32'(abcdefg), 32'd0);
    for (int c = 0; c < 40; c++) step(1'b0, 16'h5678, 4'b0, 1'b0);
    check_val("s6_fs1", 32'(o_fs[1]), 32'd1);
    check_val("s6_seg3", 32'(o_seg[3]), 32'b1111111);

    // Random stimulus against the model
    rnum  = 16'h0;
    rdots = 4'h0;
    rbz   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        rnum  = 16'($urandom) >> (4 * $urandom_range(0, 4));
        rdots = 4'($urandom);
        rbz   = 1'($urandom);
      end
      rr = ($urandom_range(0, 499) == 0);
      step(rr, rnum, rdots, rbz);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed driver for a multi-digit common-segment 7-segment display. It sits directly downstream of the arithmetic stages, for example the adder exercises. It takes a packed hex number, snapshots it once per frame, and scans the digits one at a time. For each digit it drives the shared `abcdefg`/`dot` lines and a one-hot digit enable. It replaces the one-indicator-per-value wiring once results grow past 4 bits.

## Interface

Parameters:

- `N_DIGITS`, default 4: number of digits. Digit 0 is least significant and rightmost. Legal range is 1..8.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot. Must be at least 2.
- `BLANK_CYCLES`, default 500: anti-ghosting dark cycles at the start of each slot. Legal range is 1..`REFRESH_DIV`-1.

Ports:

- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `number`, in, 4*`N_DIGITS`: hex value to show. Nibble k goes to digit k.
- `dots`, in, `N_DIGITS`: decimal point request per digit.
- `blank_zeros`, in, 1: suppress leading zeros.
- `abcdefg`, out, 7: segment lines, active-high. Bit 6 is a, bit 0 is g.
- `dot`, out, 1: decimal point line, active-high.
- `digit_en`, out, `N_DIGITS`: one-hot digit select, active-high. All-zero when dark.
- `frame_start`, out, 1: one-cycle pulse, high when a new snapshot becomes visible.

## Operation

- **Counters.** Prescaler `pre` counts 0..`REFRESH_DIV`-1 and wraps to 0. Slot index `idx` increments when `pre` wraps, counting 0..`N_DIGITS`-1 and wrapping to 0.
- **Snapshot.** At the edge ending any cycle with `pre`==0 and `idx`==0, registers load `number`, `dots` and `blank_zeros`.
  - This includes the first cycle after reset release.
  - Inputs are ignored at all other times, so the display never tears mid-frame.
- **Dark window.** A cycle with `pre` < `BLANK_CYCLES` is dark: `digit_en`=0, `abcdefg`=0, `dot`=0.
- **Lit cycles.** In all other cycles:
  - `digit_en` is one-hot at bit `idx`.
  - `dot` = snapshot `dots[idx]`.
  - `abcdefg` is the glyph of snapshot nibble `idx`.
- **Glyphs (abcdefg):**
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111
- **Leading-zero blanking.** When snapshot `blank_zeros`=1, digit k>0 is blank if nibbles k..`N_DIGITS`-1 are all zero.
  - A blank digit drives `abcdefg`=0.
  - `digit_en` and `dot` behave normally for a blank digit.
  - Digit 0 is never blanked.
- **Reset.** `reset` high at an edge clears `pre`, `idx`, the snapshot registers and all output registers to 0. This applies identically when reset arrives mid-frame or mid-slot.

## Timing

- All outputs are registered. Outputs in cycle t+1 reflect the `pre`/`idx`/snapshot state of cycle t, so latency is 1 cycle.
- Reset values:
  - `abcdefg`=0, `dot`=0, `digit_en`=0, `frame_start`=0.
  - Outputs stay 0 through the first cycle after release.
- Let cycle 0 be the first cycle with `reset` low. Then:
  - `frame_start`=1 in cycle 1 and in every cycle `N_DIGITS`*`REFRESH_DIV`*m+1.
  - Digit i is lit in cycles `i*REFRESH_DIV + BLANK_CYCLES + 1` through `(i+1)*REFRESH_DIV` of each frame, counting cycles from the frame's `pre`=0, `idx`=0 cycle.
- The snapshot edge always falls inside the dark window, because `BLANK_CYCLES` ≥ 1. Stale data from the previous frame is therefore never lit.
- Frame period is `N_DIGITS`*`REFRESH_DIV` cycles. A reset pulse restarts the frame immediately.

## Test plan

Bench parameters: `N_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2.

1. **Reset and first frame.** Hold reset 3 cycles, `number`=16'h1234, then release.
   - Outputs are all 0 through cycle 2.
   - `frame_start` is high in cycle 1 only.
   - `digit_en`=0001 with `abcdefg`=0110011 in cycles 3..8.
   - Cycles 9..10 are dark.
2. **Full scan.**
   - Digit 1 shows 1111001 in cycles 11..16.
   - Digit 2 shows 1101101 in cycles 19..24.
   - Digit 3 shows 0110000 in cycles 27..32.
   - The next `frame_start` is in cycle 33.
3. **No tearing.** Change `number` to 16'hABCD at cycle 12.
   - Digits 2 and 3 in that frame still show 1101101 and 0110000.
   - The next frame shows digit 0 = 0111101 (d) and digit 3 = 1110111 (A).
4. **Leading-zero blanking.** Set `blank_zeros`=1 with `number`=16'h0070.
   - Digits 3 and 2 show `abcdefg`=0 with `digit_en` still one-hot.
   - Digit 1 shows 1110000; digit 0 shows 1111110.
   - With `number`=0, only digit 0 shows 1111110.
5. **Decimal points.** Set `dots`=4'b0100: `dot` is 1 only during digit 2's lit cycles and 0 in every dark cycle.
6. **Reset mid-slot.** Assert reset for 1 cycle at `idx`=2, `pre`=5.
   - Next cycle: all outputs 0.
   - After release, timing restarts exactly as in scenario 1, with `frame_start` 1 cycle after release.
